// File: rtl/asrv32_dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder slice.
package asrv32_dmem_responder_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Default RAM geometry and placement in the core's address map.
  localparam int unsigned DMEM_DEFAULT_DEPTH = 1024;
  localparam logic [31:0] DMEM_DEFAULT_BASE  = 32'h0000_1000;

  // Wait-state counter geometry.
  localparam int unsigned DMEM_CNT_W    = 4;
  localparam int unsigned DMEM_MAX_WAIT = 15;

  // True when v is a non-zero power of two.
  function automatic bit dmem_is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/asrv32_bytewrite_ram.sv
// Single-port data RAM: byte-enabled synchronous write, registered read.
// The read register updates only on an enabled read and holds otherwise.
module asrv32_bytewrite_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic                           i_clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Byte-lane write or registered word read on an enabled cycle.
  // NOTE: the array and its read register carry no reset so the storage maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/asrv32_dmem_responder.sv
// Wishbone-style data-memory responder: captures one request per strobe,
// waits WAIT_STATES cycles, then performs the RAM access and pulses ack
// (with err when the address falls outside the RAM window).
module asrv32_dmem_responder
  import asrv32_dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEFAULT_DEPTH,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = DMEM_DEFAULT_BASE,
  parameter string       INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stb_data,
  input  logic        i_wr_mem_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [3:0]  i_wr_mask,
  output logic        o_ack_data,
  output logic [31:0] o_read_data,
  output logic        o_err,
  output logic        o_busy
);

  localparam int unsigned           AW        = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_CNT_W-1:0] WAIT_INIT = DMEM_CNT_W'(WAIT_STATES);

  // Reject configurations the counter or address decode cannot honour.
  if (WAIT_STATES > DMEM_MAX_WAIT) begin : g_bad_wait
    $error("asrv32_dmem_responder: WAIT_STATES must be 0..15");
  end
  if (!dmem_is_pow2(DEPTH_WORDS) || DEPTH_WORDS < 4) begin : g_bad_depth
    $error("asrv32_dmem_responder: DEPTH_WORDS must be a power of two >= 4");
  end
  if ((BASE_ADDR % (DEPTH_WORDS * 4)) != 0) begin : g_bad_base
    $error("asrv32_dmem_responder: BASE_ADDR must be DEPTH_WORDS*4 aligned");
  end

  dmem_state_e           r_state;
  logic [DMEM_CNT_W-1:0] r_cnt;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_mask;
  logic                  r_we;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_busy;
  logic                  r_rd_zero;

  logic [31:0]           w_offset;
  logic                  w_out_of_range;
  logic [AW-1:0]         w_word_idx;
  logic                  w_fire;
  logic                  w_ram_en;
  logic [31:0]           w_ram_rdata;

  // Range check on the frozen request address.
  assign w_offset       = r_addr - BASE_ADDR;
  assign w_out_of_range = (r_addr < BASE_ADDR) || ((w_offset >> 2) >= 32'(DEPTH_WORDS));
  assign w_word_idx     = w_offset[AW+1:2];

  // The RAM is touched only on the edge that enters RESP, and only in range.
  assign w_fire   = (r_state == DMEM_WAIT) && (r_cnt == '0);
  assign w_ram_en = w_fire && !w_out_of_range;

  asrv32_bytewrite_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (r_we),
    .i_be    (r_mask),
    .i_addr  (w_word_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Request FSM: capture, count wait states, respond for exactly one cycle.
  // WAIT is entered with the full wait-state count; its zero-count cycle is
  // the capture-to-access cycle, so RESP is entered WAIT_STATES+1 edges after capture.
  // NOTE: every state register here uses non-blocking assignment so all updates land together on the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= DMEM_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_we      <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      case (r_state)
        DMEM_IDLE: begin
          if (i_stb_data) begin
            r_addr  <= i_addr;
            r_wdata <= i_store_data;
            r_mask  <= i_wr_mask;
            r_we    <= i_wr_mem_en;
            r_busy  <= 1'b1;
            r_cnt   <= WAIT_INIT;
            r_state <= DMEM_WAIT;
          end
        end
        DMEM_WAIT: begin
          if (r_cnt == '0) begin
            r_ack   <= 1'b1;
            r_err   <= w_out_of_range;
            if (!r_we) begin
              r_rd_zero <= w_out_of_range;
            end
            r_state <= DMEM_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DMEM_RESP: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= DMEM_IDLE;
        end
        default: r_state <= DMEM_IDLE;
      endcase
    end
  end

  // Read data is zero after reset or an out-of-range read, else the RAM's held word.
  assign o_read_data = r_rd_zero ? 32'h0 : w_ram_rdata;
  assign o_ack_data  = r_ack;
  assign o_err       = r_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_asrv32_dmem_responder.sv
// Directed bench for asrv32_dmem_responder: a zero-wait instance and a
// three-wait instance share data inputs but have separate strobes.
module tb_asrv32_dmem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        stb0, stb3;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;
  logic        ack0, err0, busy0;
  logic        ack3, err3, busy3;
  logic [31:0] rdata0, rdata3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_mem [DEPTH];

  asrv32_dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (0),
    .BASE_ADDR   (BASE),
    .INIT_FILE   ("")
  ) u_dut0 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stb_data   (stb0),
    .i_wr_mem_en  (we),
    .i_addr       (addr),
    .i_store_data (wdata),
    .i_wr_mask    (mask),
    .o_ack_data   (ack0),
    .o_read_data  (rdata0),
    .o_err        (err0),
    .o_busy       (busy0)
  );

  asrv32_dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (3),
    .BASE_ADDR   (BASE),
    .INIT_FILE   ("")
  ) u_dut3 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stb_data   (stb3),
    .i_wr_mem_en  (we),
    .i_addr       (addr),
    .i_store_data (wdata),
    .i_wr_mask    (mask),
    .o_ack_data   (ack3),
    .o_read_data  (rdata3),
    .o_err        (err3),
    .o_busy       (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fill_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'h5A, b, ~b, 8'(i * 3)};
  endfunction

  // One request on the selected instance, started just after a negedge.
  // lat = negedges until ack is seen; ack after RESP entry => lat = WAIT_STATES + 2.
  task automatic req(input bit sel, input bit we_i, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m,
                     output int lat, output logic [31:0] rd, output logic er);
    bit got;
    we = we_i; addr = a; wdata = d; mask = m;
    if (sel) stb3 = 1'b1; else stb0 = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = sel ? ack3 : ack0;
    end
    rd = sel ? rdata3 : rdata0;
    er = sel ? err3 : err0;
    stb0 = 1'b0;
    stb3 = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL req_timeout: no ack after %0d cycles, addr %h", lat, a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    stb0 = 1'b0; stb3 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; mask = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ack0, err0, busy0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl0: got %b expected 000", {ack0, err0, busy0});
    end
    n_checks++;
    if ({ack3, err3, busy3} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl3: got %b expected 000", {ack3, err3, busy3});
    end
    n_checks++;
    if (rdata0 !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata0: got %h expected 00000000", rdata0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill;
    int lat; logic [31:0] rd; logic er;
    for (int i = 0; i < DEPTH; i++) begin
      req(1'b0, 1'b1, BASE + 32'(4 * i), fill_word(i), 4'hF, lat, rd, er);
      exp_mem[i] = fill_word(i);
      n_checks++;
      if (er !== 1'b0) begin
        n_fail++; $display("FAIL fill_err[%0d]: got %b expected 0", i, er);
      end
    end
    n_checks++;
    if (rdata0 !== 32'h0) begin
      n_fail++; $display("FAIL fill_rdata_held: got %h expected 00000000", rdata0);
    end
  endtask

  task automatic test_basic;
    int lat; logic [31:0] rd; logic er;
    req(1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, lat, rd, er);
    exp_mem[0] = 32'hDEADBEEF;
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL basic_wr_latency: got %0d expected 2", lat);
    end
    req(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL basic_rd_latency: got %0d expected 2", lat);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL basic_rd_data: got %h err %b expected deadbeef err 0", rd, er);
    end
    req(1'b0, 1'b1, 32'h1004, 32'h12345678, 4'hF, lat, rd, er);
    exp_mem[1] = 32'h12345678;
    n_checks++;
    if (rdata0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_rdata_held_over_write: got %h expected deadbeef", rdata0);
    end
    req(1'b0, 1'b0, 32'h103C, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (rd !== fill_word(15) || er !== 1'b0) begin
      n_fail++; $display("FAIL basic_last_word: got %h err %b expected %h err 0", rd, er, fill_word(15));
    end
  endtask

  task automatic test_byte_lanes;
    int lat; logic [31:0] rd; logic er;
    req(1'b0, 1'b1, 32'h1008, 32'h11223344, 4'hF, lat, rd, er);
    req(1'b0, 1'b1, 32'h1008, 32'h0000AB00, 4'b0010, lat, rd, er);
    req(1'b0, 1'b0, 32'h1008, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h1122AB44) begin
      n_fail++; $display("FAIL lanes_b1: got %h expected 1122ab44", rd);
    end
    req(1'b0, 1'b1, 32'h1008, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    n_checks++;
    if (lat !== 2 || er !== 1'b0) begin
      n_fail++; $display("FAIL lanes_mask0_ack: got lat %0d err %b expected lat 2 err 0", lat, er);
    end
    req(1'b0, 1'b0, 32'h1008, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h1122AB44) begin
      n_fail++; $display("FAIL lanes_mask0_data: got %h expected 1122ab44", rd);
    end
    req(1'b0, 1'b1, 32'h100B, 32'hA1B2C3D4, 4'b1001, lat, rd, er);
    req(1'b0, 1'b0, 32'h1008, 32'h0, 4'h0, lat, rd, er);
    exp_mem[2] = 32'hA122ABD4;
    n_checks++;
    if (rd !== 32'hA122ABD4) begin
      n_fail++; $display("FAIL lanes_b3b0: got %h expected a122abd4", rd);
    end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rd; logic er;
    req(1'b0, 1'b0, 32'h0FFC, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++; $display("FAIL oor_rd_below: got %h err %b expected 00000000 err 1", rd, er);
    end
    req(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL oor_recover: got %h err %b expected deadbeef err 0", rd, er);
    end
    req(1'b0, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++; $display("FAIL oor_rd_above: got %h err %b expected 00000000 err 1", rd, er);
    end
    req(1'b0, 1'b1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    n_checks++;
    if (er !== 1'b1) begin
      n_fail++; $display("FAIL oor_wr_below_err: got %b expected 1", er);
    end
    req(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, lat, rd, er);
    n_checks++;
    if (er !== 1'b1) begin
      n_fail++; $display("FAIL oor_wr_above_err: got %b expected 1", er);
    end
    for (int i = 0; i < DEPTH; i++) begin
      req(1'b0, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, lat, rd, er);
      n_checks++;
      if (rd !== exp_mem[i]) begin
        n_fail++; $display("FAIL oor_scoreboard[%0d]: got %h expected %h", i, rd, exp_mem[i]);
      end
    end
  endtask

  // Capture edge k is the first posedge after the drive; busy must be high
  // after edges k..k+4 and ack only after edge k+4.
  task automatic test_wait_states;
    int lat; logic [31:0] rd; logic er;
    we = 1'b1; addr = 32'h1008; wdata = 32'hCAFEF00D; mask = 4'hF;
    stb3 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy3 !== (c <= 5)) begin
        n_fail++; $display("FAIL ws3_busy[c%0d]: got %b expected %b", c, busy3, (c <= 5));
      end
      n_checks++;
      if (ack3 !== (c == 5)) begin
        n_fail++; $display("FAIL ws3_ack[c%0d]: got %b expected %b", c, ack3, (c == 5));
      end
      if (c == 5) stb3 = 1'b0;
    end
    req(1'b1, 1'b0, 32'h1008, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (lat !== 5) begin
      n_fail++; $display("FAIL ws3_rd_latency: got %0d expected 5", lat);
    end
    n_checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      n_fail++; $display("FAIL ws3_rd_data: got %h err %b expected cafef00d err 0", rd, er);
    end
  endtask

  // Strobe stays high through each ack and one further cycle before the
  // inputs switch, so a stale re-capture would produce an extra ack.
  task automatic test_back_to_back;
    logic        r_we_t [4];
    logic [31:0] r_a [4];
    logic [31:0] r_d [4];
    logic [3:0]  r_m [4];
    logic [31:0] got_rd [4];
    int          idx, extra;
    bit          pending;
    r_we_t[0] = 1'b1; r_a[0] = 32'h1018; r_d[0] = 32'h66666666; r_m[0] = 4'hF;
    r_we_t[1] = 1'b0; r_a[1] = 32'h1018; r_d[1] = 32'h0;        r_m[1] = 4'h0;
    r_we_t[2] = 1'b1; r_a[2] = 32'h101C; r_d[2] = 32'h0000BEEF; r_m[2] = 4'b0011;
    r_we_t[3] = 1'b0; r_a[3] = 32'h101C; r_d[3] = 32'h0;        r_m[3] = 4'h0;
    exp_mem[6] = 32'h66666666;
    exp_mem[7] = {exp_mem[7][31:16], 16'hBEEF};
    idx = 0; pending = 1'b0;
    for (int k = 0; k < 4; k++) got_rd[k] = 'x;
    we = r_we_t[0]; addr = r_a[0]; wdata = r_d[0]; mask = r_m[0];
    stb0 = 1'b1;
    for (int c = 0; c < 60 && idx < 4; c++) begin
      @(negedge clk);
      if (ack0) begin
        got_rd[idx] = rdata0;
        idx++;
        pending = 1'b1;
        if (idx == 4) stb0 = 1'b0;
      end else if (pending) begin
        pending = 1'b0;
        we = r_we_t[idx]; addr = r_a[idx]; wdata = r_d[idx]; mask = r_m[idx];
      end
    end
    stb0 = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack0) extra++;
    end
    n_checks++;
    if (idx !== 4 || extra !== 0) begin
      n_fail++; $display("FAIL b2b_ack_count: got %0d then %0d extra expected 4 then 0", idx, extra);
    end
    n_checks++;
    if (got_rd[1] !== 32'h66666666) begin
      n_fail++; $display("FAIL b2b_rd1: got %h expected 66666666", got_rd[1]);
    end
    n_checks++;
    if (got_rd[3] !== exp_mem[7]) begin
      n_fail++; $display("FAIL b2b_rd3: got %h expected %h", got_rd[3], exp_mem[7]);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er;
    bit saw_ack;
    req(1'b1, 1'b1, 32'h100C, 32'h0BADF00D, 4'hF, lat, rd, er);
    we = 1'b1; addr = 32'h100C; wdata = 32'h12345678; mask = 4'hF;
    stb3 = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy3 !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy3);
    end
    rst_n = 1'b0;
    stb3 = 1'b0;
    #1;
    n_checks++;
    if ({ack3, busy3} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_async: got %b expected 00", {ack3, busy3});
    end
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack3) saw_ack = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack3) saw_ack = 1'b1;
    end
    n_checks++;
    if (saw_ack !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_ack: got %b expected 0", saw_ack);
    end
    n_checks++;
    if (rdata3 !== 32'h0 || rdata0 !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_rdata_cleared: got %h/%h expected 0/0", rdata3, rdata0);
    end
    req(1'b1, 1'b0, 32'h100C, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (lat !== 5 || rd !== 32'h0BADF00D || er !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: got lat %0d data %h err %b expected 5 0badf00d 0", lat, rd, er);
    end
    req(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rstmid_ram_kept: got %h expected deadbeef", rd);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_byte_lanes();
    test_out_of_range();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
